winograd_stream_frontend: RTL



---
 rtl/wino_stream_pkg.sv | 18 +
 rtl/wino_result_serializer.sv | 39 +++
 rtl/winograd_stream_frontend.sv | 105 ++++++++++
 3 files changed

// File: rtl/wino_stream_pkg.sv
// wino_stream_pkg: shared sizes and FSM state encoding for the Winograd stream front end.
package wino_stream_pkg;
  localparam int DATA_W   = 32;
  localparam int K_N      = 3;
  localparam int IMG_ROWS = 10;
  localparam int IMG_COLS = 12;
  localparam int OUT_ROWS = IMG_ROWS - K_N + 1;
  localparam int OUT_COLS = IMG_COLS - K_N + 1;
  localparam int K_WORDS  = K_N * K_N;
  localparam int I_WORDS  = IMG_ROWS * IMG_COLS;
  localparam int O_WORDS  = OUT_ROWS * OUT_COLS;
  localparam int KW       = $clog2(K_N);
  localparam int IRW      = $clog2(IMG_ROWS);
  localparam int ICW      = $clog2(IMG_COLS);
  localparam int ORW      = $clog2(OUT_ROWS);
  localparam int OCW      = $clog2(OUT_COLS);
  typedef enum logic [2:0] {LOAD_K, LOAD_I, START, WAIT_CLR, WAIT_DONE, CAPTURE, DRAIN} wsf_state_t;
endpackage

// File: rtl/wino_result_serializer.sv
// wino_result_serializer: captures the 8x10 core result and drains it as a row-major valid/ready stream.
module wino_result_serializer
  import wino_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [DATA_W-1:0] result_in [OUT_ROWS][OUT_COLS],
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              drain_done
);
  logic [DATA_W-1:0] result_buf [OUT_ROWS][OUT_COLS];
  logic [ORW-1:0] orow;
  logic [OCW-1:0] ocol;
  logic row_end, fire;
  assign row_end    = ocol == OCW'(OUT_COLS - 1);
  assign out_last   = out_valid && row_end && orow == ORW'(OUT_ROWS - 1);
  assign out_data   = result_buf[orow][ocol];
  assign fire       = out_valid && out_ready;
  assign drain_done = fire && out_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      result_buf <= '{default: '0};
      orow       <= '0;
      ocol       <= '0;
      out_valid  <= 1'b0;
    end else if (capture) begin
      result_buf <= result_in;
      out_valid  <= 1'b1;
    end else if (fire) begin
      ocol      <= row_end ? '0 : ocol + 1'b1;
      orow      <= row_end ? (out_last ? '0 : orow + 1'b1) : orow;
      out_valid <= !out_last;
    end
  end
endmodule

// File: rtl/winograd_stream_frontend.sv
// winograd_stream_frontend: loads kernel+image words for the conv core, starts it, streams the result back.
// Optional framing check on in_last is enabled by defining WINO_STREAM_FRAME_CHECK_EN.
module winograd_stream_frontend
  import wino_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [DATA_W-1:0] kernel_out [K_N][K_N],
  output logic [DATA_W-1:0] image_out [IMG_ROWS][IMG_COLS],
  output logic              conv_start,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] result_in [OUT_ROWS][OUT_COLS],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              frame_err
);
  wsf_state_t state;
  logic [KW-1:0]  kr, kc;
  logic [IRW-1:0] ir;
  logic [ICW-1:0] ic;
  logic acc, kc_end, k_end, ic_end, i_end, capture, drain_done;
  assign in_ready = state == LOAD_K || state == LOAD_I;
  assign acc      = in_valid && in_ready;
  assign kc_end   = kc == KW'(K_N - 1);
  assign k_end    = kc_end && kr == KW'(K_N - 1);
  assign ic_end   = ic == ICW'(IMG_COLS - 1);
  assign i_end    = ic_end && ir == IRW'(IMG_ROWS - 1);
  assign busy     = !(state == LOAD_K && kr == '0 && kc == '0);
  assign capture  = state == CAPTURE;
`ifdef WINO_STREAM_FRAME_CHECK_EN
  logic early_last;
  assign early_last = acc && in_last && !(state == LOAD_I && i_end);
`else
  logic unused_last;
  assign unused_last = in_last;
  assign frame_err   = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_K;
      kr         <= '0;
      kc         <= '0;
      ir         <= '0;
      ic         <= '0;
      kernel_out <= '{default: '0};
      image_out  <= '{default: '0};
      conv_start <= 1'b0;
`ifdef WINO_STREAM_FRAME_CHECK_EN
      frame_err  <= 1'b0;
`endif
    end else begin
      conv_start <= 1'b0;
      case (state)
        LOAD_K: if (acc) begin
          kernel_out[kr][kc] <= in_data;
          kc <= kc_end ? '0 : kc + 1'b1;
          kr <= kc_end ? (k_end ? '0 : kr + 1'b1) : kr;
          state <= k_end ? LOAD_I : LOAD_K;
        end
        LOAD_I: if (acc) begin
          image_out[ir][ic] <= in_data;
          ic <= ic_end ? '0 : ic + 1'b1;
          ir <= ic_end ? (i_end ? '0 : ir + 1'b1) : ir;
          state <= i_end ? START : LOAD_I;
          conv_start <= i_end;
        end
        START:     state <= WAIT_CLR;
        WAIT_CLR:  state <= conv_done ? WAIT_CLR : WAIT_DONE;
        WAIT_DONE: state <= conv_done ? CAPTURE : WAIT_DONE;
        CAPTURE:   state <= DRAIN;
        DRAIN:     state <= drain_done ? LOAD_K : DRAIN;
        default:   state <= LOAD_K;
      endcase
`ifdef WINO_STREAM_FRAME_CHECK_EN
      // an early in_last discards the partial frame; a missing one is only flagged
      frame_err <= early_last || (acc && state == LOAD_I && i_end && !in_last);
      if (early_last) begin
        state <= LOAD_K;
        kr    <= '0;
        kc    <= '0;
        ir    <= '0;
        ic    <= '0;
      end
`endif
    end
  end
  wino_result_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .result_in  (result_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .drain_done (drain_done)
  );
endmodule
